// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
//
// Multi-cycle sequencer for the MAC extension of the pipelined RV32I core. It
// sits in EX beside the ALU. It accepts one MAC operation (MADD/MSUB/MMUL/MLOAD)
// and runs an iterative LSB-first shift-add multiply, one multiplier bit per
// cycle. It then commits the result into the architectural accumulator. The
// pipeline is held through stall_o until the commit has happened.
//
// Ports:
//   clk_i      in   1     core clock, rising edge
//   reset_i    in   1     synchronous, active-high reset
//   start_i    in   1     EX holds a valid MAC instruction this cycle
//   mac_op_i   in   2     operation (types::mac_op_t)
//   rs1_val_i  in   XLEN  operand A (forwarded)
//   rs2_val_i  in   XLEN  operand B (forwarded)
//   flush_i    in   1     kill the in-flight operation
//   stall_o    out  1     hold IF/ID/EX
//   busy_o     out  1     sequencer is multiplying or committing
//   done_o     out  1     one-cycle pulse, acc_o holds the committed result
//   acc_o      out  XLEN  architectural accumulator
// -----------------------------------------------------------------------------

package types;
   typedef enum logic [1:0] {
      MADD  = 2'd0,
      MSUB  = 2'd1,
      MMUL  = 2'd2,
      MLOAD = 2'd3
   } mac_op_t;
endpackage : types

module mac_seq_ctrl #(
   parameter int XLEN = 32
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                start_i,
   input  types::mac_op_t      mac_op_i,
   input  logic [XLEN-1:0]     rs1_val_i,
   input  logic [XLEN-1:0]     rs2_val_i,
   input  logic                flush_i,
   output logic                stall_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [XLEN-1:0]     acc_o
);

   localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ACC  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_q,   state_d;
   types::mac_op_t    op_q,      op_d;
   logic [XLEN-1:0]   op_a_q,    op_a_d;     // multiplicand, shifts left
   logic [XLEN-1:0]   op_b_q,    op_b_d;     // multiplier, shifts right
   logic [XLEN-1:0]   partial_q, partial_d;  // running product (low XLEN bits)
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [XLEN-1:0]   acc_q,     acc_d;

   // Next-state and datapath update for the sequencer.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      partial_d = partial_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;

      case (state_q)
         ST_IDLE: begin
            // A flushed instruction in EX must not be accepted.
            if (start_i && !flush_i) begin
               op_d   = mac_op_i;
               op_a_d = rs1_val_i;
               op_b_d = rs2_val_i;
               if (mac_op_i == types::MLOAD) begin
                  acc_d   = rs1_val_i;
                  state_d = ST_DONE;
               end else begin
                  partial_d = {XLEN{1'b0}};
                  cnt_d     = {CNT_W{1'b0}};
                  state_d   = ST_MUL;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_MUL: begin
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               if (op_b_q[0]) begin
                  partial_d = partial_q + op_a_q;
               end else begin
                  partial_d = partial_q;
               end
               op_a_d = {op_a_q[XLEN-2:0], 1'b0};
               op_b_d = {1'b0, op_b_q[XLEN-1:1]};
               cnt_d  = cnt_q + CNT_ONE;
               // Always all XLEN bits: fixed latency, no early exit.
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_ACC;
               end else begin
                  state_d = ST_MUL;
               end
            end
         end

         ST_ACC: begin
            // Flush wins over the commit in the same cycle.
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               case (op_q)
                  types::MMUL: acc_d = partial_q;
                  types::MADD: acc_d = acc_q + partial_q;
                  types::MSUB: acc_d = acc_q - partial_q;
                  default:     acc_d = acc_q;
               endcase
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            // The commit already happened; flush cannot undo it here.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         op_q      <= types::MADD;
         op_a_q    <= {XLEN{1'b0}};
         op_b_q    <= {XLEN{1'b0}};
         partial_q <= {XLEN{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         acc_q     <= {XLEN{1'b0}};
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         partial_q <= partial_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
      end
   end

   // The start term is combinational so the pipeline holds in the issue cycle.
   // It is masked by reset so that a reset cycle never stalls on start.
   assign stall_o = ((state_q == ST_IDLE) && start_i && !flush_i && !reset_i)
                  || (state_q == ST_MUL) || (state_q == ST_ACC);
   assign busy_o  = (state_q == ST_MUL) || (state_q == ST_ACC);
   assign done_o  = (state_q == ST_DONE);
   assign acc_o   = acc_q;

endmodule : mac_seq_ctrl
